// File: rtl/tlc_pkg.sv
// Shared types and encodings for the traffic-light request path.
// The direction encoding is shared with traffic_light_controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_e;

  localparam logic [2:0] INSTR_NORMAL = 3'b000;
  localparam int         EMERG_BIT    = 2;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Round-robin pick: the first set bit at or after last+1, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last + 2'd1;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/req_debouncer.sv
// Per-direction sensor debouncer; emits a one-cycle pulse when the sensor
// first completes DEBOUNCE consecutive high samples.
module req_debouncer #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic qualified_o
);

  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);

  logic [3:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!req_i)                cnt_d = 4'd0;
    else if (cnt_q != DEB_MAX) cnt_d = cnt_q + 4'd1;
  end

  // Saturation keeps a held sensor from pulsing again until it drops low.
  assign qualified_o = req_i && (cnt_q == DEB_MAX - 4'd1);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tlc_request_sequencer.sv
// Turns debounced ambulance sensors and a phase timer into the controller's
// valid/instruction stream, with round-robin emergencies and a post-emergency hold-off.
module tlc_request_sequencer
  import tlc_pkg::*;
#(
  parameter int DATA_WIDTH  = 3,
  parameter int NUM_DIRS    = 4,
  parameter int DEBOUNCE    = 3,
  parameter int HOLD_CYCLES = 5,
  parameter int PERIOD      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DIRS-1:0]   amb_req,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [NUM_DIRS-1:0]   pending,
  output logic                  busy
);

  if (DATA_WIDTH != 3 || NUM_DIRS != 4) begin : g_bad_shape
    $error("tlc_request_sequencer: DATA_WIDTH must be 3 and NUM_DIRS must be 4");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("tlc_request_sequencer: DEBOUNCE must be 1..15");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("tlc_request_sequencer: HOLD_CYCLES must be 1..255");
  end
  if (PERIOD < 4 || PERIOD > 65535) begin : g_bad_period
    $error("tlc_request_sequencer: PERIOD must be 4..65535");
  end

  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD - 1);
  localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_CYCLES - 1);

  logic [NUM_DIRS-1:0]   qualified;
  logic [NUM_DIRS-1:0]   pending_q, pending_d;
  logic [1:0]            last_q;
  logic [1:0]            grant;
  logic                  emerg_go;
  state_e                state_q;
  logic [15:0]           period_q;
  logic [7:0]            hold_q;
  logic                  valid_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] instr_q;

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_deb
    req_debouncer #(
      .DEBOUNCE (DEBOUNCE)
    ) u_deb (
      .clk         (clk),
      .rst_n       (reset),
      .req_i       (amb_req[d]),
      .qualified_o (qualified[d])
    );
  end

  // Arbitration looks only at already-latched requests; a clear beats a same-edge set.
  always_comb begin
    grant     = rr_pick(pending_q, last_q);
    emerg_go  = (state_q == IDLE) && (|pending_q);
    pending_d = pending_q | qualified;
    if (emerg_go) pending_d[grant] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      last_q    <= 2'd3;
      period_q  <= 16'd0;
      hold_q    <= 8'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      instr_q   <= INSTR_NORMAL;
    end else begin
      pending_q <= pending_d;
      valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (emerg_go) begin
            state_q  <= ISSUE;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            instr_q  <= {1'b1, grant};
            last_q   <= grant;
            period_q <= 16'd0;
          end else if (period_q == PERIOD_LAST) begin
            state_q  <= ISSUE;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            instr_q  <= INSTR_NORMAL;
            period_q <= 16'd0;
          end else begin
            period_q <= period_q + 16'd1;
          end
        end
        ISSUE: begin
          if (instr_q[EMERG_BIT]) begin
            state_q <= HOLD;
            hold_q  <= HOLD_LAST;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_q == 8'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid       = valid_q;
  assign instruction = instr_q;
  assign pending     = pending_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tlc_request_sequencer.sv
// Self-checking bench: each test pushes expected (instruction, cycle) issues to a
// scoreboard that a negedge monitor pops whenever valid is seen.
module tb_tlc_request_sequencer;
  import tlc_pkg::*;

  typedef struct {
    logic [2:0] instr;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] amb_req;
  logic       valid;
  logic [2:0] instruction;
  logic [3:0] pending;
  logic       busy;

  int   checks;
  int   errors;
  int   cyc;
  logic prev_valid;
  exp_t exp_q[$];

  tlc_request_sequencer #(
    .DATA_WIDTH  (3),
    .NUM_DIRS    (4),
    .DEBOUNCE    (3),
    .HOLD_CYCLES (5),
    .PERIOD      (16)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .amb_req     (amb_req),
    .valid       (valid),
    .instruction (instruction),
    .pending     (pending),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges since the last reset release.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (valid) begin
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL back_to_back_valid cyc=%0d", cyc);
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue cyc=%0d instr=%b", cyc, instruction);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (instruction !== e.instr || cyc != e.cyc) begin
            errors++;
            $display("FAIL issue got instr=%b at cyc=%0d, expected instr=%b at cyc=%0d",
                     instruction, cyc, e.instr, e.cyc);
          end
        end
      end
      prev_valid = valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [2:0] instr, input int c);
    exp_t e;
    e.instr = instr;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    amb_req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    to_cyc(limit);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_issues remaining=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_pending(input string name, input logic [3:0] exp_p);
    checks++;
    if (pending !== exp_p) begin
      errors++;
      $display("FAIL %s pending cyc=%0d got=%b expected=%b", name, cyc, pending, exp_p);
    end
  endtask

  task automatic check_busy(input string name, input logic exp_b);
    checks++;
    if (busy !== exp_b) begin
      errors++;
      $display("FAIL %s busy cyc=%0d got=%b expected=%b", name, cyc, busy, exp_b);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (valid !== 1'b0 || instruction !== 3'b000 || pending !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs got valid=%b instr=%b pending=%b busy=%b expected all zero",
               name, valid, instruction, pending, busy);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    amb_req = 4'b0000;
    #1;
    check_all_zero("reset_async");
    @(negedge clk);
    check_all_zero("reset_held");
  endtask

  task automatic test_normal();
    do_reset();
    push_exp(INSTR_NORMAL, 16);
    push_exp(INSTR_NORMAL, 33);
    push_exp(INSTR_NORMAL, 50);
    to_cyc(15);
    check_busy("normal_pre_issue", 1'b0);
    to_cyc(16);
    check_busy("normal_issue", 1'b1);
    to_cyc(17);
    check_busy("normal_after_issue", 1'b0);
    for (int c = 18; c <= 52; c++) begin
      to_cyc(c);
      check_pending("normal", 4'b0000);
    end
    wait_drain("normal", 52);
  endtask

  task automatic test_emergency();
    do_reset();
    push_exp({1'b1, DIR_S}, 4);
    push_exp(INSTR_NORMAL, 26);
    amb_req = 4'b0100;
    to_cyc(2);
    check_pending("emerg_before_qual", 4'b0000);
    to_cyc(3);
    amb_req = 4'b0000;
    check_pending("emerg_qualified", 4'b0100);
    to_cyc(4);
    check_pending("emerg_served", 4'b0000);
    check_busy("emerg_issue", 1'b1);
    to_cyc(8);
    checks++;
    if (instruction !== 3'b110 || valid !== 1'b0) begin
      errors++;
      $display("FAIL emerg_instr_hold got instr=%b valid=%b expected instr=110 valid=0",
               instruction, valid);
    end
    to_cyc(9);
    check_busy("emerg_hold_last", 1'b1);
    to_cyc(10);
    check_busy("emerg_hold_done", 1'b0);
    wait_drain("emergency", 28);
  endtask

  task automatic test_glitch();
    do_reset();
    push_exp(INSTR_NORMAL, 16);
    amb_req = 4'b0001;
    to_cyc(2);
    amb_req = 4'b0000;
    to_cyc(3);
    amb_req = 4'b0001;
    to_cyc(5);
    amb_req = 4'b0000;
    for (int c = 6; c <= 18; c++) begin
      to_cyc(c);
      check_pending("glitch", 4'b0000);
    end
    wait_drain("glitch", 18);
  endtask

  task automatic test_all_dirs();
    do_reset();
    push_exp(3'b100, 4);
    push_exp(3'b101, 11);
    push_exp(3'b110, 18);
    push_exp(3'b111, 25);
    push_exp(INSTR_NORMAL, 47);
    amb_req = 4'b1111;
    to_cyc(3);
    check_pending("all_dirs_qual", 4'b1111);
    to_cyc(4);
    check_pending("all_dirs_first", 4'b1110);
    to_cyc(11);
    check_pending("all_dirs_second", 4'b1100);
    to_cyc(25);
    check_pending("all_dirs_last", 4'b0000);
    wait_drain("all_dirs", 49);
    amb_req = 4'b0000;
  endtask

  task automatic test_held_sensor();
    do_reset();
    push_exp(3'b101, 4);
    push_exp(INSTR_NORMAL, 26);
    push_exp(INSTR_NORMAL, 43);
    push_exp(3'b101, 56);
    push_exp(INSTR_NORMAL, 78);
    amb_req = 4'b0010;
    to_cyc(40);
    check_pending("held_no_reset", 4'b0000);
    to_cyc(50);
    amb_req = 4'b0000;
    to_cyc(52);
    amb_req = 4'b0010;
    to_cyc(54);
    check_pending("held_requal_pre", 4'b0000);
    to_cyc(55);
    check_pending("held_requal", 4'b0010);
    wait_drain("held_sensor", 80);
    amb_req = 4'b0000;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    push_exp(3'b100, 4);
    amb_req = 4'b0101;
    to_cyc(3);
    amb_req = 4'b0000;
    to_cyc(7);
    check_busy("hold_busy", 1'b1);
    check_pending("hold_pending", 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_hold");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("pre_reset_issue", 0);
    push_exp(INSTR_NORMAL, 16);
    for (int c = 1; c <= 18; c++) begin
      to_cyc(c);
      check_pending("after_reset", 4'b0000);
    end
    wait_drain("reset_in_hold", 20);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    prev_valid = 1'b0;
    test_reset();
    test_normal();
    test_emergency();
    test_glitch();
    test_all_dirs();
    test_held_sensor();
    test_reset_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
